// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the latency-aware hazard scoreboard.
package hazard_pkg;

  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned REG_AW  = 5;

  // Countdown width needed to hold latencies 0..max_lat.
  function automatic int unsigned lat_w(input int unsigned max_lat);
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_cnt_slot.sv
// One scoreboard entry: a down-counter with load that holds an in-flight result's remaining latency.
module hazard_cnt_slot #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         set_i,
  input  logic [W-1:0] set_val_i,
  output logic [W-1:0] cnt_o,
  output logic         nz_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // A load from a newly issued producer wins over the decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (set_i) begin
      cnt_d = set_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-aware RAW/WAW hazard unit for the in-order pipeline: stalls ID against in-flight results
// tracked per register and counts stall cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG    = 32,
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned LATW   = lat_w(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ir_ID,
  input  logic             id_valid,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_rd_we,
  input  logic [LATW-1:0]  id_lat,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [NREG-1:0]  pending,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [LATW-1:0] LatMax = LATW'(MAX_LAT);

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [LATW-1:0]   lat_eff;
  logic [LATW-1:0]   cnt [NREG];
  logic              raw_hz, waw_hz, wr_en;
  logic              unused_ir;

  assign rs1 = ir_ID[RS1_LSB +: REG_AW];
  assign rs2 = ir_ID[RS2_LSB +: REG_AW];
  assign rd  = ir_ID[RD_LSB +: REG_AW];
  assign unused_ir = ^{ir_ID[31:25], ir_ID[14:12], ir_ID[6:0]};

  // Out-of-range latencies are treated as the slowest legal unit.
  assign lat_eff = (id_lat > LatMax) ? LatMax : id_lat;

  assign raw_hz = (id_use_rs1 && (cnt[rs1] != '0)) || (id_use_rs2 && (cnt[rs2] != '0));
  // A younger write must not land before an older one still in flight.
  assign waw_hz = id_rd_we && (rd != '0) && (cnt[rd] > lat_eff);

  assign stall = id_valid && !flush && (raw_hz || waw_hz);
  assign issue = id_valid && !flush && !stall;

  // Zero-latency results are forwardable at once, so they never occupy an entry.
  assign wr_en = issue && id_rd_we && (rd != '0) && (lat_eff != '0);

  assign cnt[0]     = '0;
  assign pending[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_slot
    localparam logic [REG_AW-1:0] Idx = REG_AW'(r);
    hazard_cnt_slot #(
      .W (LATW)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_i     (wr_en && (rd == Idx)),
      .set_val_i (lat_eff),
      .cnt_o     (cnt[r]),
      .nz_o      (pending[r])
    );
  end

  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle model comparison plus directed literal checks.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir_ID;
  logic        id_valid, id_use_rs1, id_use_rs2, id_rd_we, flush;
  logic [3:0]  id_lat;
  logic        stall, issue;
  logic [31:0] pending;
  logic [31:0] stall_cycles;

  logic [4:0]  t_rs1, t_rs2, t_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign ir_ID = {7'b0, t_rs2, t_rs1, 3'b000, t_rd, 7'h33};

  hazard_scoreboard #(
    .NREG    (32),
    .MAX_LAT (8),
    .CNT_W   (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ir_ID        (ir_ID),
    .id_valid     (id_valid),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd_we     (id_rd_we),
    .id_lat       (id_lat),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .pending      (pending),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic u1, input logic [4:0] a, input logic u2,
                       input logic [4:0] b, input logic we, input logic [4:0] d,
                       input logic [3:0] l, input logic f);
    id_valid = v; id_use_rs1 = u1; t_rs1 = a; id_use_rs2 = u2; t_rs2 = b;
    id_rd_we = we; t_rd = d; id_lat = l; flush = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: remaining latency per register as plain integers.
  int     mcnt [32];
  int     mnext [32];
  longint msc, msc_next;

  initial begin : model_cmp
    bit          e_stall, e_issue, raw, waw;
    int          le;
    logic [31:0] e_pend;
    for (int r = 0; r < 32; r++) begin mcnt[r] = 0; mnext[r] = 0; end
    msc = 0; msc_next = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int r = 0; r < 32; r++) begin mcnt[r] = 0; mnext[r] = 0; end
        msc = 0; msc_next = 0;
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_issue", {63'd0, issue}, {63'd0, id_valid && !flush});
        chk("rst_pending", {32'd0, pending}, 64'd0);
        chk("rst_stall_cycles", {32'd0, stall_cycles}, 64'd0);
      end else begin
        le  = (int'(id_lat) > 8) ? 8 : int'(id_lat);
        raw = (id_use_rs1 && mcnt[t_rs1] != 0) || (id_use_rs2 && mcnt[t_rs2] != 0);
        waw = id_rd_we && t_rd != 0 && mcnt[t_rd] > le;
        e_stall = id_valid && !flush && (raw || waw);
        e_issue = id_valid && !flush && !e_stall;
        for (int r = 0; r < 32; r++) e_pend[r] = (mcnt[r] != 0);
        chk("stall", {63'd0, stall}, {63'd0, e_stall});
        chk("issue", {63'd0, issue}, {63'd0, e_issue});
        chk("pending", {32'd0, pending}, {32'd0, e_pend});
        chk("stall_cycles", {32'd0, stall_cycles}, msc);
        for (int r = 0; r < 32; r++) mnext[r] = (mcnt[r] > 0) ? mcnt[r] - 1 : 0;
        if (e_issue && id_rd_we && t_rd != 0 && le != 0) mnext[t_rd] = le;
        msc_next = (e_stall && msc != 64'hFFFF_FFFF) ? msc + 1 : msc;
      end
      @(posedge clk);
      if (rst_n) begin
        for (int r = 0; r < 32; r++) mcnt[r] = mnext[r];
        msc = msc_next;
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    // Consumer in ID during reset: must issue, nothing is pending.
    drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd4, 4'd0, 1'b0);
    #2;
    chk("reset_issue", {63'd0, issue}, 64'd1);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    tick();

    // Load-use: one bubble.
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 4'd1, 1'b0);
    #1 chk("lu_lw_issue", {63'd0, issue}, 64'd1);
    tick();
    drive(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 4'd0, 1'b0);
    #1 chk("lu_stall", {63'd0, stall}, 64'd1);
    tick();
    #1 chk("lu_issue", {63'd0, issue}, 64'd1);
    chk("lu_stall_cycles", {32'd0, stall_cycles}, 64'd1);
    tick();

    // Long latency: div x7 with lat 6.
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 4'd6, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd11, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1 chk("div_stall", {63'd0, stall}, 64'd1);
      chk("div_pend7", {63'd0, pending[7]}, 64'd1);
      tick();
    end
    #1 chk("div_issue", {63'd0, issue}, 64'd1);
    chk("div_pend7_clr", {63'd0, pending[7]}, 64'd0);
    chk("div_stall_cycles", {32'd0, stall_cycles}, 64'd7);
    tick();

    // WAW: div x8 lat 5 then lw x8 lat 1 -> 4 stalls.
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 4'd5, 1'b0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("waw_stall", {63'd0, stall}, 64'd1);
      tick();
    end
    #1 chk("waw_issue", {63'd0, issue}, 64'd1);
    tick();
    idle();
    #1 chk("waw_pend8", {63'd0, pending[8]}, 64'd1);
    tick();
    #1 chk("waw_pend8_clr", {63'd0, pending[8]}, 64'd0);

    // x0 never becomes pending; unused rs2 field never stalls.
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 4'd1, 1'b0);
    tick();
    #1 chk("x0_pending", {32'd0, pending}, 64'd0);
    drive(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 4'd0, 1'b0);
    #1 chk("x0_stall", {63'd0, stall}, 64'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 4'd3, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd1, 1'b0, 5'd9, 1'b1, 5'd13, 4'd0, 1'b0);
    #1 chk("nouse_stall", {63'd0, stall}, 64'd0);
    chk("nouse_issue", {63'd0, issue}, 64'd1);
    tick();
    idle();
    repeat (3) tick();

    // Flush priority: stalled consumer that also writes x5 is killed.
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 4'd2, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 4'd7, 1'b1);
    #1 chk("fl_stall", {63'd0, stall}, 64'd0);
    chk("fl_issue", {63'd0, issue}, 64'd0);
    tick();
    flush = 1'b0;
    #1 chk("fl_pend5", {63'd0, pending[5]}, 64'd1);
    chk("fl_restall", {63'd0, stall}, 64'd1);
    tick();
    #1 chk("fl_issue2", {63'd0, issue}, 64'd1);
    tick();
    idle();
    repeat (8) tick();

    // Clamp: lat 15 behaves as 8.
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 4'd15, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1 chk("clamp_stall", {63'd0, stall}, 64'd1);
      tick();
    end
    #1 chk("clamp_issue", {63'd0, issue}, 64'd1);
    chk("clamp_stall_cycles", {32'd0, stall_cycles}, 64'd20);
    tick();

    // Reset mid-stall with cnt[9] = 4.
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 4'd5, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0);
    tick();
    #1 chk("mr_stall_before", {63'd0, stall}, 64'd1);
    chk("mr_sc_before", {32'd0, stall_cycles}, 64'd21);
    rst_n = 1'b0;
    #1 chk("mr_pending", {32'd0, pending}, 64'd0);
    chk("mr_stall", {63'd0, stall}, 64'd0);
    chk("mr_stall_cycles", {32'd0, stall_cycles}, 64'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("mr_issue_after", {63'd0, issue}, 64'd1);
    chk("mr_stall_after", {63'd0, stall}, 64'd0);
    tick();
    idle();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised latency-aware hazard unit for the in-order RISC-V pipeline; successor to the single-cycle load-use detector. It keeps a per-register countdown scoreboard of in-flight results with producer latencies from 0 to MAX_LAT. It stalls the instruction in ID on RAW (read-after-write) and WAW (write-after-write) conflicts against those results. It sits between the ID decoder and the ID/EX pipeline register and drives the IF/ID hold and ID/EX bubble insertion.

## Interface
Parameters:
- NREG, 32, architectural register count (x0 hard-wired zero)
- MAX_LAT, 8, largest producer latency in cycles after EX entry; LATW = $clog2(MAX_LAT+1)
- CNT_W, 32, width of stall performance counter

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- ir_ID  input  32  instruction in ID; rs1 = [19:15], rs2 = [24:20], rd = [11:7]
- id_valid  input  1  ID holds a valid instruction
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_rd_we  input  1  ID instruction writes rd
- id_lat  input  LATW  cycles until result is forwardable (0 = ALU, 1 = load, n = multi-cycle unit)
- flush  input  1  branch/exception kill of ID instruction this cycle
- stall  output  1  hold IF/ID, inject bubble into ID/EX
- issue  output  1  ID instruction advances to EX this cycle
- pending  output  NREG  per-register in-flight mask (cnt != 0)
- stall_cycles  output  CNT_W  count of cycles with stall = 1

## Operation
- Scoreboard: cnt[r] is LATW bits per register, r = 1..NREG-1. cnt[0] is constant 0 and x0 is never pending.
- RAW hazard = (id_use_rs1 && cnt[rs1] != 0) || (id_use_rs2 && cnt[rs2] != 0).
- WAW hazard = id_rd_we && rd != 0 && cnt[rd] > id_lat. The older result would otherwise land after the younger one.
- stall = id_valid && !flush && (RAW || WAW). Combinational.
- issue = id_valid && !flush && !stall.
- Update each cycle, applied in priority order:
  - On issue with id_rd_we, rd != 0 and id_lat != 0: cnt[rd] <= id_lat. This overrides any decrement to the same register.
  - Otherwise every nonzero cnt[r] decrements by 1.
  - An issue with id_lat = 0 leaves cnt[rd] on its decrement path. WAW already guarantees cnt[rd] was 0.
- flush has priority over stall. A flushed ID instruction never writes the scoreboard. Entries of older, already-issued producers keep counting; flush does not clear them.
- stall_cycles increments on every cycle with stall = 1 and saturates at all-ones.
- id_lat > MAX_LAT is illegal input. The block clamps it to MAX_LAT.

## Timing
- Reset (async assert, sync-released by the top level): all cnt = 0, pending = 0, stall = 0, issue follows its inputs, stall_cycles = 0.
- Reset asserted mid-stall clears every entry at once. After release, the ID instruction issues with no stall.
- Latency semantics: a producer issuing in cycle t with id_lat = k sets cnt = k at t+1. A dependent in ID stalls in cycles t+1..t+k and issues at t+k+1.
- A load (k = 1) followed immediately by a consumer gives exactly one bubble.
- Back-to-back producers to the same rd: the younger one overwrites cnt when it issues.
- stall is registered nowhere; the path is input to output within one cycle. pending and stall_cycles reflect state after the last clock edge.

## Structure
- hazard_pkg holds:
  - field constants RS1_LSB = 15, RS2_LSB = 20, RD_LSB = 7, REG_AW = 5
  - function lat_w(max_lat) returning $clog2(max_lat+1)
- One sub-module, hazard_cnt_slot, instantiated NREG-1 times with a generate loop. Each instance is a single LATW-bit down-counter with load (set), load value, decrement and nonzero flag.
- The top level does field extraction, RAW/WAW compare, the stall/issue equations and the perf counter.

## Test plan
- Load-use: lw x5 issues with lat = 1, then add x6,x5,x1 in ID → stall = 1 for exactly 1 cycle, issue the next cycle, stall_cycles = 1.
- Long latency: div x7 issues with lat = 6, then consumer of x7 → stall for 6 cycles, then issue. pending[7] is 1 for 6 cycles, then 0.
- WAW: div x8 (lat = 5), then lw x8 (lat = 1) one cycle later (cnt[8] = 5 > 1) → stall until cnt[8] ≤ 1. Then the lw issues and sets cnt[8] = 1.
- x0 and no-use: lw x0 with lat = 1, then a consumer of x0; and a consumer with id_use_rs2 = 0 whose rs2 field hits a pending register → stall = 0 in both cases.
- Flush priority: consumer stalled on x5 while flush = 1 → stall = 0, issue = 0, cnt unchanged apart from decrement.
- Reset mid-operation: assert rst_n = 0 while cnt[9] = 4 and stall = 1 → pending = 0, stall = 0 and stall_cycles = 0 immediately, without waiting for a clock edge.
